// File: rtl/elevator_ctrl_n.sv
// SCAN-style N-floor elevator car controller: request latching, travel and door timing, Moore outputs.
// Optional fire-recall mode is compiled in when ELEV_FIRE_RECALL_EN is defined.
module elevator_ctrl_n #(
    parameter int N_FLOORS      = 8,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 6,
    parameter int CLOSE_CYCLES  = 2,
    localparam int FW = (N_FLOORS > 2) ? $clog2(N_FLOORS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_FLOORS-1:0] req,
    input  logic                door_open_btn,
    input  logic                door_close_btn,
    input  logic                overload,
`ifdef ELEV_FIRE_RECALL_EN
    input  logic                fire_recall,
`endif
    output logic [FW-1:0]       floor,
    output logic                up,
    output logic                down,
    output logic                door_open,
    output logic                door_close,
    output logic                dir,
    output logic [N_FLOORS-1:0] pending
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UP,
        S_DOWN,
        S_OPEN,
        S_CLOSE
    } state_t;

    localparam logic [15:0] TRAVEL_LAST = 16'(TRAVEL_CYCLES - 1);
    localparam logic [15:0] DOOR_LOAD   = 16'(DOOR_CYCLES);
    localparam logic [15:0] CLOSE_LOAD  = 16'(CLOSE_CYCLES);

    state_t              state, state_nxt;
    logic [FW-1:0]       floor_nxt, nf_up, nf_dn;
    logic                dir_nxt;
    logic [15:0]         tcnt, tcnt_nxt;
    logic [15:0]         timer, timer_nxt;
    logic [N_FLOORS-1:0] pending_nxt, req_eff, clr;
    logic                fire;
    logic                any_above, any_below, beyond_up, beyond_dn;
    logic                here_req, here_pend, reopen;

`ifdef ELEV_FIRE_RECALL_EN
    assign fire = fire_recall;
`else
    assign fire = 1'b0;
`endif

    // During recall new requests are dropped and the latched set is wiped.
    assign req_eff   = fire ? '0 : req;
    assign here_req  = req_eff[floor];
    assign here_pend = pending[floor];
    assign nf_up     = floor + FW'(1);
    assign nf_dn     = floor - FW'(1);

    always_comb begin
        clr = '0;
        if (state == S_OPEN) clr[floor] = 1'b1;
    end

    assign pending_nxt = fire ? '0 : ((pending | req_eff) & ~clr);

    // "beyond" looks past the floor the car is about to reach, used to stop at the last target.
    always_comb begin
        any_above = 1'b0;
        any_below = 1'b0;
        beyond_up = 1'b0;
        beyond_dn = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (pending[i]) begin
                if (i > int'(floor))     any_above = 1'b1;
                if (i < int'(floor))     any_below = 1'b1;
                if (i > int'(floor) + 1) beyond_up = 1'b1;
                if (i < int'(floor) - 1) beyond_dn = 1'b1;
            end
        end
    end

    assign reopen = door_open_btn || overload || here_req || (fire && floor == '0);

    always_comb begin
        state_nxt = state;
        floor_nxt = floor;
        dir_nxt   = dir;
        tcnt_nxt  = tcnt;
        timer_nxt = timer;
        case (state)
            S_IDLE: begin
                if (fire) begin
                    if (floor == '0) begin
                        state_nxt = S_OPEN;
                        timer_nxt = DOOR_LOAD;
                    end else begin
                        state_nxt = S_DOWN;
                        dir_nxt   = 1'b0;
                        tcnt_nxt  = '0;
                    end
                end else if (here_pend || door_open_btn) begin
                    state_nxt = S_OPEN;
                    timer_nxt = DOOR_LOAD;
                end else if (any_above && (dir || !any_below)) begin
                    state_nxt = S_UP;
                    dir_nxt   = 1'b1;
                    tcnt_nxt  = '0;
                end else if (any_below) begin
                    state_nxt = S_DOWN;
                    dir_nxt   = 1'b0;
                    tcnt_nxt  = '0;
                end
            end
            S_UP: begin
                if (tcnt == TRAVEL_LAST) begin
                    tcnt_nxt  = '0;
                    floor_nxt = nf_up;
                    if (fire) begin
                        state_nxt = S_DOWN;
                        dir_nxt   = 1'b0;
                    end else if (pending[nf_up]) begin
                        state_nxt = S_OPEN;
                        timer_nxt = DOOR_LOAD;
                    end else if (!beyond_up) begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    tcnt_nxt = tcnt + 16'd1;
                end
            end
            S_DOWN: begin
                if (tcnt == TRAVEL_LAST) begin
                    tcnt_nxt  = '0;
                    floor_nxt = nf_dn;
                    if (fire) begin
                        if (nf_dn == '0) begin
                            state_nxt = S_OPEN;
                            timer_nxt = DOOR_LOAD;
                        end
                    end else if (pending[nf_dn]) begin
                        state_nxt = S_OPEN;
                        timer_nxt = DOOR_LOAD;
                    end else if (!beyond_dn) begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    tcnt_nxt = tcnt + 16'd1;
                end
            end
            S_OPEN: begin
                // Open requests and overload take priority over any close request.
                if (reopen) begin
                    timer_nxt = DOOR_LOAD;
                end else if ((door_close_btn && !fire) || timer <= 16'd1) begin
                    state_nxt = S_CLOSE;
                    timer_nxt = CLOSE_LOAD;
                end else begin
                    timer_nxt = timer - 16'd1;
                end
            end
            S_CLOSE: begin
                if (reopen) begin
                    state_nxt = S_OPEN;
                    timer_nxt = DOOR_LOAD;
                end else if (timer <= 16'd1) begin
                    state_nxt = S_IDLE;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer - 16'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            floor   <= '0;
            dir     <= 1'b1;
            tcnt    <= '0;
            timer   <= '0;
            pending <= '0;
        end else begin
            state   <= state_nxt;
            floor   <= floor_nxt;
            dir     <= dir_nxt;
            tcnt    <= tcnt_nxt;
            timer   <= timer_nxt;
            pending <= pending_nxt;
        end
    end

    assign up         = (state == S_UP);
    assign down       = (state == S_DOWN);
    assign door_open  = (state == S_OPEN);
    assign door_close = (state == S_CLOSE);

endmodule
